// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of the shared memory
// wrapper. Port 0 is the I-cache refill port, port 1 the D-cache miss/write
// port. One transaction is in flight at a time: accept, present to memory,
// then steer the single response back to the port that issued the request.
//
// Handshake rule on every channel: a transfer happens on a rising clock edge
// where valid and ready are both high. A source keeps valid and its payload
// stable until that edge. Ready may depend combinationally on valid.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // requester 0 (I-cache refill)
  input  logic              m0_req_valid_i,
  output logic              m0_req_ready_o,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic              m0_we_i,
  input  logic [DATA_W-1:0] m0_data_wr_i,
  output logic              m0_rsp_valid_o,
  input  logic              m0_rsp_ready_i,
  output logic [ADDR_W-1:0] m0_rsp_addr_o,
  output logic [LINE_W-1:0] m0_data_line_o,
  // requester 1 (D-cache miss/write)
  input  logic              m1_req_valid_i,
  output logic              m1_req_ready_o,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic              m1_we_i,
  input  logic [DATA_W-1:0] m1_data_wr_i,
  output logic              m1_rsp_valid_o,
  input  logic              m1_rsp_ready_i,
  output logic [ADDR_W-1:0] m1_rsp_addr_o,
  output logic [LINE_W-1:0] m1_data_line_o,
  // memory wrapper
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_data_wr_o,
  input  logic              mem_rsp_valid_i,
  output logic              mem_rsp_ready_o,
  input  logic [ADDR_W-1:0] mem_rsp_addr_i,
  input  logic [LINE_W-1:0] mem_data_line_i,
  // status
  output logic              busy_o,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_owner;
  logic                r_last_grant;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_data;

  logic                w_any_req;
  logic                w_winner;
  logic                w_accept;
  logic                w_owner_rsp_ready;
  logic                w_rsp_done;

  // Round-robin pick: a lone requester wins, a tie goes to the port not granted last.
  always_comb begin
    w_any_req = m0_req_valid_i | m1_req_valid_i;
    if (m0_req_valid_i && m1_req_valid_i) begin
      w_winner = ~r_last_grant;
    end else begin
      w_winner = m1_req_valid_i;
    end
    w_owner_rsp_ready = r_owner ? m1_rsp_ready_i : m0_rsp_ready_i;
  end

  // Next-state and handshake outputs of the IDLE/REQ/RSP controller.
  always_comb begin
    w_next_state    = r_state;
    m0_req_ready_o  = 1'b0;
    m1_req_ready_o  = 1'b0;
    m0_rsp_valid_o  = 1'b0;
    m1_rsp_valid_o  = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_rsp_ready_o = 1'b0;
    w_accept        = 1'b0;
    w_rsp_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Drain any stray response (e.g. one that outlived a reset).
        mem_rsp_ready_o = 1'b1;
        m0_req_ready_o  = w_any_req & ~w_winner;
        m1_req_ready_o  = w_any_req &  w_winner;
        w_accept        = w_any_req;
        if (w_any_req) w_next_state = ST_REQ;
      end
      ST_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) w_next_state = ST_RSP;
      end
      ST_RSP: begin
        m0_rsp_valid_o  = mem_rsp_valid_i & ~r_owner;
        m1_rsp_valid_o  = mem_rsp_valid_i &  r_owner;
        mem_rsp_ready_o = w_owner_rsp_ready;
        w_rsp_done      = mem_rsp_valid_i & w_owner_rsp_ready;
        if (w_rsp_done) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request latch and arbitration history. last_grant resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_data       <= '0;
    end else begin
      if (w_accept) begin
        r_owner <= w_winner;
        r_addr  <= w_winner ? m1_addr_i    : m0_addr_i;
        r_we    <= w_winner ? m1_we_i      : m0_we_i;
        r_data  <= w_winner ? m1_data_wr_i : m0_data_wr_i;
      end
      if (w_rsp_done) begin
        r_last_grant <= r_owner;
      end
    end
  end

  // Response payload is broadcast; only rsp_valid qualifies it.
  assign m0_rsp_addr_o  = mem_rsp_addr_i;
  assign m1_rsp_addr_o  = mem_rsp_addr_i;
  assign m0_data_line_o = mem_data_line_i;
  assign m1_data_line_o = mem_data_line_i;

  assign mem_addr_o    = r_addr;
  assign mem_we_o      = r_we;
  assign mem_data_wr_o = r_data;
  assign busy_o        = (r_state != ST_IDLE);
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table for arbitration,
// routing and response back-pressure, plus hand sequences for a stalled write
// and a reset that lands mid-transaction.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LINE_W = 128;

  logic              clk_i;
  logic              rst_i;
  logic              m0_req_valid_i, m1_req_valid_i;
  logic              m0_req_ready_o, m1_req_ready_o;
  logic [ADDR_W-1:0] m0_addr_i, m1_addr_i;
  logic              m0_we_i, m1_we_i;
  logic [DATA_W-1:0] m0_data_wr_i, m1_data_wr_i;
  logic              m0_rsp_valid_o, m1_rsp_valid_o;
  logic              m0_rsp_ready_i, m1_rsp_ready_i;
  logic [ADDR_W-1:0] m0_rsp_addr_o, m1_rsp_addr_o;
  logic [LINE_W-1:0] m0_data_line_o, m1_data_line_o;
  logic              mem_req_valid_o, mem_req_ready_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_data_wr_o;
  logic              mem_rsp_valid_i, mem_rsp_ready_o;
  logic [ADDR_W-1:0] mem_rsp_addr_i;
  logic [LINE_W-1:0] mem_data_line_i;
  logic              busy_o;
  logic [1:0]        dbg_state_o;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_W(LINE_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_valid_i(m0_req_valid_i), .m0_req_ready_o(m0_req_ready_o),
    .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_data_wr_i(m0_data_wr_i),
    .m0_rsp_valid_o(m0_rsp_valid_o), .m0_rsp_ready_i(m0_rsp_ready_i),
    .m0_rsp_addr_o(m0_rsp_addr_o), .m0_data_line_o(m0_data_line_o),
    .m1_req_valid_i(m1_req_valid_i), .m1_req_ready_o(m1_req_ready_o),
    .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_data_wr_i(m1_data_wr_i),
    .m1_rsp_valid_o(m1_rsp_valid_o), .m1_rsp_ready_i(m1_rsp_ready_i),
    .m1_rsp_addr_o(m1_rsp_addr_o), .m1_data_line_o(m1_data_line_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_data_wr_o(mem_data_wr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
    .mem_rsp_addr_i(mem_rsp_addr_i), .mem_data_line_i(mem_data_line_i),
    .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  // Clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Safety net: the test is fixed-length, this only fires if something wedges.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, act=running req=finished");
    $fatal(1, "watchdog");
  end

  // Per-cycle vector: inputs for one cycle and the outputs expected before the edge.
  // Flags order: {m0_req_ready, m1_req_ready, mem_req_valid, mem_we,
  //               m0_rsp_valid, m1_rsp_valid, mem_rsp_ready, busy}
  typedef struct {
    logic        m0v;
    logic        m1v;
    logic [31:0] m0a;
    logic [31:0] m1a;
    logic        memrdy;
    logic        rspv;
    logic        m0rr;
    logic        m1rr;
    logic [7:0]  exp_flags;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic m0v, input logic m1v, input logic [31:0] m0a,
                     input logic [31:0] m1a, input logic memrdy, input logic rspv,
                     input logic m0rr, input logic m1rr, input logic [7:0] fl,
                     input logic [31:0] ea);
    vec_t v;
    v.m0v = m0v; v.m1v = m1v; v.m0a = m0a; v.m1a = m1a;
    v.memrdy = memrdy; v.rspv = rspv; v.m0rr = m0rr; v.m1rr = m1rr;
    v.exp_flags = fl; v.exp_addr = ea;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=%0h req=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] flags();
    return {m0_req_ready_o, m1_req_ready_o, mem_req_valid_o, mem_we_o,
            m0_rsp_valid_o, m1_rsp_valid_o, mem_rsp_ready_o, busy_o};
  endfunction

  task automatic idle_inputs();
    m0_req_valid_i = 0; m1_req_valid_i = 0;
    m0_addr_i = '0; m1_addr_i = '0; m0_we_i = 0; m1_we_i = 0;
    m0_data_wr_i = 32'h0000_1111; m1_data_wr_i = 32'h0000_2222;
    m0_rsp_ready_i = 0; m1_rsp_ready_i = 0;
    mem_req_ready_i = 0; mem_rsp_valid_i = 0;
    mem_rsp_addr_i = '0; mem_data_line_i = '0;
  endtask

  initial begin
    logic [127:0] line_a;
    line_a = 128'hAABB_CCDD_EEFF_0011_2233_4455_6677_8899;

    // Alternating grants from reset, both ports always requesting.
    for (int k = 0; k < 2; k++) begin
      add(1,1,32'h10,32'h20,1,1,1,1, 8'b1000_0010, 32'h0);
      add(1,1,32'h10,32'h20,1,1,1,1, 8'b0010_0001, 32'h10);
      add(1,1,32'h10,32'h20,1,1,1,1, 8'b0000_1011, 32'h0);
      add(1,1,32'h10,32'h20,1,1,1,1, 8'b0100_0010, 32'h0);
      add(1,1,32'h10,32'h20,1,1,1,1, 8'b0010_0001, 32'h20);
      add(1,1,32'h10,32'h20,1,1,1,1, 8'b0000_0111, 32'h0);
    end
    // Single read on port 0, addr 0x100, memory ready at once.
    add(1,0,32'h100,32'h0,0,0,0,0, 8'b1000_0010, 32'h0);
    add(0,0,32'h0,32'h0,1,0,0,0,   8'b0010_0001, 32'h100);
    add(0,0,32'h0,32'h0,0,1,1,0,   8'b0000_1011, 32'h0);
    // Port 0 read with an empty response cycle and 4 cycles of rsp back-pressure.
    add(1,0,32'h200,32'h0,0,0,0,0, 8'b1000_0010, 32'h0);
    add(0,0,32'h0,32'h0,1,0,0,0,   8'b0010_0001, 32'h200);
    add(0,0,32'h0,32'h0,0,0,1,0,   8'b0000_0011, 32'h0);
    for (int k = 0; k < 4; k++)
      add(0,0,32'h0,32'h0,0,1,0,1, 8'b0000_1001, 32'h0);
    add(0,0,32'h0,32'h0,0,1,1,0,   8'b0000_1011, 32'h0);
    add(0,0,32'h0,32'h0,0,0,0,0,   8'b0000_0010, 32'h0);

    // Reset and its output values.
    idle_inputs();
    rst_i = 1'b1;
    #1;
    check("reset_flags", {120'h0, flags()}, {120'h0, 8'b0000_0010});
    check("reset_state", {126'h0, dbg_state_o}, 128'h0);
    check("reset_mem_addr", {96'h0, mem_addr_o}, 128'h0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // Table run.
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk_i);
      m0_req_valid_i = tbl[i].m0v; m1_req_valid_i = tbl[i].m1v;
      m0_addr_i = tbl[i].m0a; m1_addr_i = tbl[i].m1a;
      mem_req_ready_i = tbl[i].memrdy; mem_rsp_valid_i = tbl[i].rspv;
      m0_rsp_ready_i = tbl[i].m0rr; m1_rsp_ready_i = tbl[i].m1rr;
      mem_data_line_i = line_a;
      #1;
      check($sformatf("vec%0d_flags", i), {120'h0, flags()}, {120'h0, tbl[i].exp_flags});
      if (tbl[i].exp_flags[5])
        check($sformatf("vec%0d_addr", i), {96'h0, mem_addr_o}, {96'h0, tbl[i].exp_addr});
      if (tbl[i].exp_flags[3])
        check($sformatf("vec%0d_line", i), m0_data_line_o, line_a);
    end

    // Port 1 write held in REQ for 5 cycles while port 0 waits.
    @(negedge clk_i);
    idle_inputs();
    m1_req_valid_i = 1; m1_addr_i = 32'h4000_0010; m1_we_i = 1; m1_data_wr_i = 32'hDEAD_BEEF;
    #1;
    check("wr_accept", {126'h0, m0_req_ready_o, m1_req_ready_o}, 128'h1);
    @(negedge clk_i);
    m1_req_valid_i = 0; m1_addr_i = '0; m1_we_i = 0; m1_data_wr_i = '0;
    m0_req_valid_i = 1; m0_addr_i = 32'h10;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("wr_stall%0d_fields", k),
            {62'h0, mem_req_valid_o, mem_we_o, mem_addr_o, mem_data_wr_o},
            {62'h0, 1'b1, 1'b1, 32'h4000_0010, 32'hDEAD_BEEF});
      check($sformatf("wr_stall%0d_no_grant", k), {126'h0, m0_req_ready_o, busy_o}, 128'h1);
      @(negedge clk_i);
    end
    mem_req_ready_i = 1;
    #1;
    check("wr_req_handshake", {127'h0, mem_req_valid_o}, 128'h1);
    @(negedge clk_i);
    mem_req_ready_i = 0;
    mem_rsp_valid_i = 1; mem_rsp_addr_i = 32'h4000_0010; mem_data_line_i = 128'h1234;
    m1_rsp_ready_i = 1;
    #1;
    check("wr_rsp_route", {126'h0, m0_rsp_valid_o, m1_rsp_valid_o}, 128'h1);
    check("wr_rsp_addr", {64'h0, m1_rsp_addr_o, m0_rsp_addr_o}, {64'h0, 32'h4000_0010, 32'h4000_0010});
    check("wr_rsp_line", m1_data_line_o, 128'h1234);
    @(negedge clk_i);
    mem_rsp_valid_i = 0; m1_rsp_ready_i = 0;
    #1;
    check("waiting_port0_granted", {126'h0, m0_req_ready_o, m1_req_ready_o}, 128'h2);
    @(negedge clk_i);
    m0_req_valid_i = 0;
    #1;
    check("in_req_before_reset", {126'h0, mem_req_valid_o, busy_o}, 128'h3);

    // Asynchronous reset mid-REQ, then a stray response and a tie.
    #1 rst_i = 1'b1;
    #1;
    check("async_reset_flags", {120'h0, flags()}, {120'h0, 8'b0000_0010});
    check("async_reset_latch", {96'h0, mem_addr_o}, 128'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    mem_rsp_valid_i = 1; mem_rsp_addr_i = 32'h10;
    #1;
    check("stray_drained", {125'h0, mem_rsp_ready_o, m0_rsp_valid_o, m1_rsp_valid_o}, 128'h4);
    @(negedge clk_i);
    mem_rsp_valid_i = 0;
    m0_req_valid_i = 1; m0_addr_i = 32'h10;
    m1_req_valid_i = 1; m1_addr_i = 32'h20;
    #1;
    check("tie_after_reset", {126'h0, m0_req_ready_o, m1_req_ready_o}, 128'h2);
    @(negedge clk_i);
    idle_inputs();
    #1;
    check("tie_winner_addr", {96'h0, mem_addr_o}, {96'h0, 32'h10});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
